vegeta_weight_compressor: RTL and testbench

Upstream feeder for a column of `vegeta_mac` PEs. It accepts dense M-element weight blocks and compresses each one according to the current structured-sparsity mode (dense, 2:4 or 1:4). It emits a stream of `{metadata, value}` words in exactly the PE `weight_in` format, so the output drives a PE column's `weight_in` and `weight_transferring_in` directly. It also flags blocks that violate the selected sparsity pattern.

---
 rtl/vegeta_weight_compressor.sv | 154 +++++++++++++++
 tb/tb_vegeta_weight_compressor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vegeta_weight_compressor.sv
// vegeta_weight_compressor
//   Compresses dense M-lane weight blocks into {lane_index, value} words in the
//   PE weight_in format, according to the structured-sparsity mode (dense,
//   2:4, 1:4). It flags blocks that break the selected sparsity pattern.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   gemm_mode      0 dense, 1 2:4, 2 1:4, 3 reserved (dense + error); sampled at accept
//   in_valid/in_ready/in_block/in_last   dense block input handshake
//   out_valid/out_ready/out_weight/out_last   compressed word output handshake
//   err_sparsity   sticky flag for an overfull block or reserved mode
//   blk_count      blocks accepted since reset (wraps)
module vegeta_weight_compressor #(
  parameter int MUL_DATAWIDTH  = 16,
  parameter int META_DATA_SIZE = 2,
  parameter int M              = 4,
  parameter int CNT_W          = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [1:0]                             gemm_mode,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [MUL_DATAWIDTH*M-1:0]             in_block,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [MUL_DATAWIDTH+META_DATA_SIZE-1:0] out_weight,
  output logic                                   out_last,
  output logic                                   err_sparsity,
  output logic [CNT_W-1:0]                       blk_count
);

  localparam int WW = MUL_DATAWIDTH + META_DATA_SIZE;
  localparam int NW = $clog2(M + 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                    state;
  logic [META_DATA_SIZE-1:0] idx;
  logic [NW-1:0]             n_q;
  logic                      last_q;
  logic [WW-1:0]             word_q    [M];

  logic [WW-1:0]             comp_word [M];
  logic [NW-1:0]             comp_n;
  logic                      comp_over;
  logic                      idx_at_end;
  logic                      accept;

  // Two-pass lane selection: first the nonzero lanes (up to N), then the
  // lowest zero lanes as padding. Packing the selected set in lane order
  // yields the ascending-index word list directly.
  always_comb begin
    int unsigned               n_lim;
    int unsigned               taken;
    int unsigned               nz;
    logic [META_DATA_SIZE-1:0] k;
    logic                      sparse;
    logic [M-1:0]              sel;
    logic [M-1:0]              pad;
    logic [MUL_DATAWIDTH-1:0]  lane;
    logic [MUL_DATAWIDTH-1:0]  val;

    sparse = (gemm_mode == 2'd1) || (gemm_mode == 2'd2);
    case (gemm_mode)
      2'd1:    n_lim = 2;
      2'd2:    n_lim = 1;
      default: n_lim = M;
    endcase

    sel   = '0;
    pad   = '0;
    taken = 0;
    nz    = 0;
    k     = '0;
    lane  = '0;
    val   = '0;
    comp_word = '{default: '0};

    for (int unsigned i = 0; i < M; i++) begin
      lane = in_block[i*MUL_DATAWIDTH +: MUL_DATAWIDTH];
      if (lane[MUL_DATAWIDTH-2:0] != '0) begin
        nz++;
        if (taken < n_lim) begin
          sel[i] = 1'b1;
          taken++;
        end
      end
    end

    for (int unsigned i = 0; i < M; i++) begin
      if (!sel[i] && taken < n_lim) begin
        sel[i] = 1'b1;
        pad[i] = sparse;
        taken++;
      end
    end

    for (int unsigned i = 0; i < M; i++) begin
      if (sel[i]) begin
        lane = in_block[i*MUL_DATAWIDTH +: MUL_DATAWIDTH];
        val  = pad[i] ? '0 : lane;
        comp_word[k] = {META_DATA_SIZE'(i), val};
        k = k + META_DATA_SIZE'(1);
      end
    end

    comp_n    = NW'(n_lim);
    comp_over = nz > n_lim;
  end

  assign idx_at_end = (32'(idx) + 32'd1) == 32'(n_q);
  assign in_ready   = rst_n && ((state == IDLE) || (out_ready && idx_at_end));
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      n_q          <= '0;
      last_q       <= 1'b0;
      word_q       <= '{default: '0};
      out_valid    <= 1'b0;
      out_weight   <= '0;
      out_last     <= 1'b0;
      err_sparsity <= 1'b0;
      blk_count    <= '0;
    end else if (accept) begin
      // Covers both IDLE accepts and the back-to-back handoff on the last word.
      state      <= EMIT;
      idx        <= '0;
      n_q        <= comp_n;
      last_q     <= in_last;
      word_q     <= comp_word;
      out_valid  <= 1'b1;
      out_weight <= comp_word[0];
      out_last   <= in_last && (comp_n == NW'(1));
      blk_count  <= blk_count + CNT_W'(1);
      if (comp_over || gemm_mode == 2'd3) err_sparsity <= 1'b1;
    end else if (state == EMIT && out_ready) begin
      if (!idx_at_end) begin
        idx        <= idx + META_DATA_SIZE'(1);
        out_weight <= word_q[idx + META_DATA_SIZE'(1)];
        out_last   <= last_q && ((32'(idx) + 32'd2) == 32'(n_q));
      end else begin
        state     <= IDLE;
        idx       <= '0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vegeta_weight_compressor.sv
module tb_vegeta_weight_compressor;

  localparam int DW = 16;
  localparam int MW = 2;
  localparam int M  = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      gemm_mode;
  logic            in_valid;
  logic            in_ready;
  logic [DW*M-1:0] in_block;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [DW+MW-1:0] out_weight;
  logic            out_last;
  logic            err_sparsity;
  logic [CW-1:0]   blk_count;

  int nvec = 0;
  int nerr = 0;

  vegeta_weight_compressor #(
    .MUL_DATAWIDTH (DW),
    .META_DATA_SIZE(MW),
    .M             (M),
    .CNT_W         (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gemm_mode   (gemm_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_block    (in_block),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_weight  (out_weight),
    .out_last    (out_last),
    .err_sparsity(err_sparsity),
    .blk_count   (blk_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    gemm_mode = 2'd0; in_block = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
    gemm_mode = 2'd0; in_block = 64'h4040_0000_4000_3F80;
    tick(); tick();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    nvec++; if (out_weight !== 18'h0) begin nerr++; $display("FAIL reset_out_weight: got %h want 0", out_weight); end
    nvec++; if (out_last !== 1'b0) begin nerr++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    nvec++; if (err_sparsity !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", err_sparsity); end
    nvec++; if (blk_count !== 4'd0) begin nerr++; $display("FAIL reset_blk_count: got %0d want 0", blk_count); end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_dense();
    logic [DW+MW-1:0] exp [4];
    exp[0] = {2'd0, 16'h3F80}; exp[1] = {2'd1, 16'h4000};
    exp[2] = {2'd2, 16'h0000}; exp[3] = {2'd3, 16'h4040};
    do_reset();
    gemm_mode = 2'd0; in_block = 64'h4040_0000_4000_3F80; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL dense_valid%0d: got %b want 1", k, out_valid); end
      nvec++; if (out_weight !== exp[k]) begin nerr++; $display("FAIL dense_word%0d: got %h want %h", k, out_weight, exp[k]); end
      nvec++; if (out_last !== 1'b0) begin nerr++; $display("FAIL dense_last%0d: got %b want 0", k, out_last); end
      tick();
    end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL dense_done: got %b want 0", out_valid); end
    nvec++; if (blk_count !== 4'd1) begin nerr++; $display("FAIL dense_blk_count: got %0d want 1", blk_count); end
  endtask

  task automatic test_sparse_2to4();
    logic [DW+MW-1:0] exp [4];
    do_reset();
    gemm_mode = 2'd1;
    // clean block
    exp[0] = {2'd0, 16'h3F80}; exp[1] = {2'd2, 16'h4000};
    in_block = 64'h0000_4000_0000_3F80; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nvec++; if (out_valid !== 1'b1 || out_weight !== exp[k]) begin nerr++; $display("FAIL s24_clean_word%0d: got v=%b %h want v=1 %h", k, out_valid, out_weight, exp[k]); end
      tick();
    end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL s24_clean_done: got %b want 0", out_valid); end
    nvec++; if (err_sparsity !== 1'b0) begin nerr++; $display("FAIL s24_clean_err: got %b want 0", err_sparsity); end
    // underfull, -0 in lane 1 counts as zero and pads with value 0
    exp[0] = {2'd0, 16'h0000}; exp[1] = {2'd1, 16'h0000};
    in_block = 64'h0000_0000_8000_0000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nvec++; if (out_valid !== 1'b1 || out_weight !== exp[k]) begin nerr++; $display("FAIL s24_under_word%0d: got v=%b %h want v=1 %h", k, out_valid, out_weight, exp[k]); end
      tick();
    end
    nvec++; if (err_sparsity !== 1'b0) begin nerr++; $display("FAIL s24_under_err: got %b want 0", err_sparsity); end
    nvec++; if (blk_count !== 4'd2) begin nerr++; $display("FAIL s24_blk_count: got %0d want 2", blk_count); end
  endtask

  task automatic test_overfull();
    logic [DW+MW-1:0] exp [4];
    exp[0] = {2'd0, 16'h3F80}; exp[1] = {2'd2, 16'h4000};
    gemm_mode = 2'd1;
    in_block = 64'h4040_4000_0000_3F80; in_valid = 1'b1;
    nvec++; if (err_sparsity !== 1'b0) begin nerr++; $display("FAIL over_err_before: got %b want 0", err_sparsity); end
    tick();
    in_valid = 1'b0;
    nvec++; if (err_sparsity !== 1'b1) begin nerr++; $display("FAIL over_err_accept1: got %b want 1", err_sparsity); end
    for (int k = 0; k < 2; k++) begin
      nvec++; if (out_valid !== 1'b1 || out_weight !== exp[k]) begin nerr++; $display("FAIL over_word%0d: got v=%b %h want v=1 %h", k, out_valid, out_weight, exp[k]); end
      tick();
    end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL over_done: got %b want 0", out_valid); end
    // a later clean block keeps the sticky flag
    in_block = 64'h0000_4000_0000_3F80; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    nvec++; if (err_sparsity !== 1'b1) begin nerr++; $display("FAIL over_err_sticky: got %b want 1", err_sparsity); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    gemm_mode = 2'd2; out_ready = 1'b1;
    in_block = 64'h0000_0000_4100_0000; in_valid = 1'b1; in_last = 1'b0;
    tick();
    nvec++; if (out_valid !== 1'b1 || out_weight !== {2'd1, 16'h4100}) begin nerr++; $display("FAIL b2b_word0: got v=%b %h want v=1 %h", out_valid, out_weight, {2'd1, 16'h4100}); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
    nvec++; if (out_last !== 1'b0) begin nerr++; $display("FAIL b2b_last0: got %b want 0", out_last); end
    in_block = 64'h4200_0000_0000_0000;
    tick();
    nvec++; if (out_valid !== 1'b1 || out_weight !== {2'd3, 16'h4200}) begin nerr++; $display("FAIL b2b_word1: got v=%b %h want v=1 %h", out_valid, out_weight, {2'd3, 16'h4200}); end
    nvec++; if (out_last !== 1'b0) begin nerr++; $display("FAIL b2b_last1: got %b want 0", out_last); end
    out_ready = 1'b0; in_block = 64'h0000_0000_0000_0000; in_last = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL b2b_stall_ready: got %b want 0", in_ready); end
    for (int k = 0; k < 2; k++) begin
      tick();
      nvec++; if (out_valid !== 1'b1 || out_weight !== {2'd3, 16'h4200} || out_last !== 1'b0) begin nerr++; $display("FAIL b2b_stall%0d: got v=%b %h l=%b want v=1 %h l=0", k, out_valid, out_weight, out_last, {2'd3, 16'h4200}); end
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    nvec++; if (out_valid !== 1'b1 || out_weight !== {2'd0, 16'h0000}) begin nerr++; $display("FAIL b2b_word2: got v=%b %h want v=1 %h", out_valid, out_weight, {2'd0, 16'h0000}); end
    nvec++; if (out_last !== 1'b1) begin nerr++; $display("FAIL b2b_last2: got %b want 1", out_last); end
    tick();
    nvec++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin nerr++; $display("FAIL b2b_done: got v=%b l=%b want v=0 l=0", out_valid, out_last); end
    nvec++; if (blk_count !== 4'd3) begin nerr++; $display("FAIL b2b_blk_count: got %0d want 3", blk_count); end
    nvec++; if (err_sparsity !== 1'b0) begin nerr++; $display("FAIL b2b_err: got %b want 0", err_sparsity); end
  endtask

  task automatic test_reset_mid_block();
    logic [DW+MW-1:0] exp [4];
    do_reset();
    // reserved mode: dense output plus error flag
    gemm_mode = 2'd3; in_block = 64'h4040_0000_4000_3F80; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    nvec++; if (out_weight !== {2'd0, 16'h3F80} || err_sparsity !== 1'b1) begin nerr++; $display("FAIL rsvd_word0: got %h err=%b want %h err=1", out_weight, err_sparsity, {2'd0, 16'h3F80}); end
    tick();
    nvec++; if (out_weight !== {2'd1, 16'h4000}) begin nerr++; $display("FAIL rsvd_word1: got %h want %h", out_weight, {2'd1, 16'h4000}); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    nvec++; if (out_valid !== 1'b0 || blk_count !== 4'd0 || err_sparsity !== 1'b0) begin nerr++; $display("FAIL mid_reset: got v=%b cnt=%0d err=%b want v=0 cnt=0 err=0", out_valid, blk_count, err_sparsity); end
    tick();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_reset_no_resume: got %b want 0", out_valid); end
    exp[0] = {2'd0, 16'h1111}; exp[1] = {2'd1, 16'h2222};
    exp[2] = {2'd2, 16'h3333}; exp[3] = {2'd3, 16'h4444};
    gemm_mode = 2'd0; in_block = 64'h4444_3333_2222_1111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      nvec++; if (out_valid !== 1'b1 || out_weight !== exp[k]) begin nerr++; $display("FAIL post_reset_word%0d: got v=%b %h want v=1 %h", k, out_valid, out_weight, exp[k]); end
      tick();
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    gemm_mode = 2'd2; out_ready = 1'b1; in_last = 1'b0;
    in_block = 64'h0000_0000_0000_3C00; in_valid = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end else begin
        tick();
      end
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL wrap_valid%0d: got %b want 1", k, out_valid); end
      if (k == 15) begin
        nvec++; if (blk_count !== 4'd15) begin nerr++; $display("FAIL wrap_cnt15: got %0d want 15", blk_count); end
      end
    end
    nvec++; if (blk_count !== 4'd0) begin nerr++; $display("FAIL wrap_cnt16: got %0d want 0", blk_count); end
    tick();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL wrap_done: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_dense();
    test_sparse_2to4();
    test_overfull();
    test_back_to_back();
    test_reset_mid_block();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
